// File: rtl/aes_pkg.sv
// Shared types and constants for the AES streaming controller.
package aes_pkg;

  localparam int AES_BLOCK_W   = 128;
  localparam int AES_CNT_WIDTH = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KEY,
    ST_LOAD,
    ST_FIRE,
    ST_RUN,
    ST_OUT,
    ST_DONE
  } aes_ctrl_state_t;

endpackage

// File: rtl/aes_stream_ctrl.sv
// Sequences one AES job: stacker block -> AES core -> unstacker, one block at a time.
//
// state | meaning
// IDLE  | waiting for start_i
// KEY   | key expansion requested, waiting for key_ready_i
// LOAD  | accepting a plaintext block from the stacker
// FIRE  | one-cycle encrypt start to the core
// RUN   | waiting for core_done_i
// OUT   | result offered to the unstacker
// DONE  | one-cycle job-complete pulse
module aes_stream_ctrl
  import aes_pkg::*;
#(
  parameter int CNT_WIDTH = AES_CNT_WIDTH
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clr_i,
  input  logic                   start_i,
  input  logic [CNT_WIDTH-1:0]   num_blocks_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [AES_BLOCK_W-1:0] in_data_i,
  output logic                   stacker_clr_o,
  output logic                   key_load_o,
  input  logic                   key_ready_i,
  output logic                   core_start_o,
  output logic [AES_BLOCK_W-1:0] core_data_o,
  input  logic                   core_done_i,
  input  logic [AES_BLOCK_W-1:0] core_data_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [AES_BLOCK_W-1:0] out_data_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [CNT_WIDTH-1:0]   blocks_done_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  aes_ctrl_state_t        r_state;
  logic [CNT_WIDTH-1:0]   r_remaining;
  logic [CNT_WIDTH-1:0]   r_blocks_done;
  logic [AES_BLOCK_W-1:0] r_core_data;
  logic [AES_BLOCK_W-1:0] r_out_data;
  logic                   r_in_ready;
  logic                   r_out_valid;
  logic                   r_stacker_clr;
  logic                   r_key_load;
  logic                   r_core_start;
  logic                   r_busy;
  logic                   r_done;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      r_state       <= ST_IDLE;
      r_remaining   <= '0;
      r_blocks_done <= '0;
      r_core_data   <= '0;
      r_out_data    <= '0;
      r_in_ready    <= 1'b0;
      r_out_valid   <= 1'b0;
      r_stacker_clr <= 1'b0;
      r_key_load    <= 1'b0;
      r_core_start  <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_stacker_clr <= 1'b0;
      r_key_load    <= 1'b0;
      r_core_start  <= 1'b0;
      r_done        <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_remaining   <= num_blocks_i;
            r_blocks_done <= '0;
            r_busy        <= 1'b1;
            // An empty job skips key expansion and leaves the stacker alone.
            if (num_blocks_i == '0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state       <= ST_KEY;
              r_stacker_clr <= 1'b1;
              r_key_load    <= 1'b1;
            end
          end
        end
        ST_KEY: begin
          if (key_ready_i) begin
            r_state    <= ST_LOAD;
            r_in_ready <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (in_valid_i) begin
            r_core_data  <= in_data_i;
            r_in_ready   <= 1'b0;
            r_core_start <= 1'b1;
            r_state      <= ST_FIRE;
          end
        end
        ST_FIRE: begin
          r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (core_done_i) begin
            r_out_data  <= core_data_i;
            r_out_valid <= 1'b1;
            r_state     <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (out_ready_i) begin
            r_out_valid   <= 1'b0;
            r_blocks_done <= r_blocks_done + CNT_ONE;
            if (r_remaining != '0) begin
              r_remaining <= r_remaining - CNT_ONE;
            end
            if (r_remaining <= CNT_ONE) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state    <= ST_LOAD;
              r_in_ready <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready_o    = r_in_ready;
  assign out_valid_o   = r_out_valid;
  assign stacker_clr_o = r_stacker_clr;
  assign key_load_o    = r_key_load;
  assign core_start_o  = r_core_start;
  assign core_data_o   = r_core_data;
  assign out_data_o    = r_out_data;
  assign busy_o        = r_busy;
  assign done_o        = r_done;
  assign blocks_done_o = r_blocks_done;

endmodule

// File: tb/tb_aes_stream_ctrl.sv
// Bench for aes_stream_ctrl: behavioural AES core stand-in plus an output scoreboard.
module tb_aes_stream_ctrl;
  import aes_pkg::*;

  localparam int CW     = 16;
  localparam int CORE_L = 10;

  logic             clk_i = 1'b0;
  logic             rst_i, clr_i, start_i;
  logic [CW-1:0]    num_blocks_i;
  logic             in_valid_i, in_ready_o;
  logic [127:0]     in_data_i;
  logic             stacker_clr_o, key_load_o, key_ready_i, core_start_o;
  logic [127:0]     core_data_o, core_data_i, out_data_o;
  logic             core_done_i, out_valid_o, out_ready_i, busy_o, done_o;
  logic [CW-1:0]    blocks_done_o;

  logic             model_done = 1'b0;
  logic [127:0]     model_data = '0;
  logic             spur_done, core_abort;
  logic [127:0]     spur_data;

  int               n_err = 0;
  int               n_chk = 0;
  int               n_core_start = 0, n_key_load = 0, n_stclr = 0, n_done = 0;
  logic [127:0]     sb_q[$];
  logic [127:0]     last_pt = '0;
  logic [127:0]     prev_data = '0;
  logic             prev_stall = 1'b0;

  assign core_done_i = model_done | spur_done;
  assign core_data_i = spur_done ? spur_data : model_data;

  aes_stream_ctrl #(.CNT_WIDTH(CW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(clr_i), .start_i(start_i),
    .num_blocks_i(num_blocks_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_data_i(in_data_i), .stacker_clr_o(stacker_clr_o), .key_load_o(key_load_o),
    .key_ready_i(key_ready_i), .core_start_o(core_start_o), .core_data_o(core_data_o),
    .core_done_i(core_done_i), .core_data_i(core_data_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .out_data_o(out_data_o), .busy_o(busy_o),
    .done_o(done_o), .blocks_done_o(blocks_done_o)
  );

  always #5 clk_i = ~clk_i;

  // Stand-in cipher: any fixed bijection is enough to tell blocks apart.
  function automatic logic [127:0] aes_model(input logic [127:0] p);
    return {p[95:0], p[127:96]} ^ 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Core: done pulse CORE_L cycles after the start pulse, abandoned on core_abort.
  always begin : core_model
    int cnt;
    logic [127:0] pt;
    cnt = 0;
    pt = '0;
    forever begin
      @(posedge clk_i);
      #1;
      model_done = 1'b0;
      if (core_abort) cnt = 0;
      else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          model_done = 1'b1;
          model_data = aes_model(pt);
        end
      end
      if (core_start_o) begin
        cnt = CORE_L;
        pt  = core_data_o;
      end
    end
  end

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic mon_step();
    if (rst_i || clr_i) begin
      sb_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (in_valid_i && in_ready_o) begin
        sb_q.push_back(aes_model(in_data_i));
        last_pt = in_data_i;
      end
      if (core_start_o) begin
        n_core_start++;
        check_val("core_data", core_data_o, last_pt);
      end
      if (key_load_o) n_key_load++;
      if (stacker_clr_o) n_stclr++;
      if (done_o) n_done++;
      if (out_valid_o && prev_stall) check_val("out_stable", out_data_o, prev_data);
      if (out_valid_o && out_ready_i) begin
        if (sb_q.size() == 0) check_val("sb_underflow", 1'b0, 1'b1);
        else check_val("sb_out", out_data_o, sb_q.pop_front());
      end
      prev_stall = out_valid_o && !out_ready_i;
      prev_data  = out_data_o;
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
    mon_step();
    @(posedge clk_i);
    #2;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_in_ready"}, in_ready_o, 0);
    check_val({tag, "_out_valid"}, out_valid_o, 0);
    check_val({tag, "_stclr"}, stacker_clr_o, 0);
    check_val({tag, "_key_load"}, key_load_o, 0);
    check_val({tag, "_core_start"}, core_start_o, 0);
    check_val({tag, "_core_data"}, core_data_o, 0);
    check_val({tag, "_out_data"}, out_data_o, 0);
    check_val({tag, "_busy"}, busy_o, 0);
    check_val({tag, "_done"}, done_o, 0);
    check_val({tag, "_blocks"}, blocks_done_o, 0);
  endtask

  function automatic logic [2:0] t1_state(input int c);
    if (c == 0 || c == 16) return ST_IDLE;
    if (c == 1) return ST_KEY;
    if (c == 2) return ST_LOAD;
    if (c == 3) return ST_FIRE;
    if (c == 14) return ST_OUT;
    if (c == 15) return ST_DONE;
    return ST_RUN;
  endfunction

  task automatic run_job(input string tag, input int n, input int max_gap, input int stall,
                         input int key_dly, input bit spur);
    int t, cs0, kl0, sc0, dn0;
    cs0 = n_core_start; kl0 = n_key_load; sc0 = n_stclr; dn0 = n_done;
    if (key_dly > 0) key_ready_i = 1'b0;
    start_i = 1'b1;
    num_blocks_i = CW'(n);
    tick();
    start_i = 1'b0;
    if (n > 0) begin
      repeat (key_dly) begin
        check_val({tag, "_key_wait_rdy"}, in_ready_o, 0);
        tick();
      end
      key_ready_i = 1'b1;
      for (int k = 1; k <= n; k++) begin
        if (spur) begin
          t = 0;
          while (!in_ready_o && t < 50) begin tick(); t++; end
          start_i = 1'b1; num_blocks_i = '1; spur_done = 1'b1; spur_data = rand128();
          tick();
          start_i = 1'b0; spur_done = 1'b0;
          check_val({tag, "_spur_load_state"}, dut.r_state, ST_LOAD);
          check_val({tag, "_spur_load_blocks"}, blocks_done_o, k - 1);
        end
        repeat ((max_gap > 0) ? $urandom_range(0, max_gap) : 0) tick();
        in_data_i = rand128();
        in_valid_i = 1'b1;
        t = 0;
        while (!in_ready_o && t < 100) begin tick(); t++; end
        if (t >= 100) check_val({tag, "_in_timeout"}, 0, 1);
        tick();
        in_valid_i = 1'b0;
        t = 0;
        while (!out_valid_o && t < 100) begin tick(); t++; end
        if (t >= 100) check_val({tag, "_out_timeout"}, 0, 1);
        for (int s = 0; s < stall; s++) begin
          if (spur && s == 1) begin
            start_i = 1'b1; spur_done = 1'b1; spur_data = rand128();
          end
          tick();
          start_i = 1'b0; spur_done = 1'b0;
        end
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        check_val({tag, "_blocks_step"}, blocks_done_o, k);
      end
    end
    check_val({tag, "_done_pulse"}, done_o, 1);
    check_val({tag, "_done_busy"}, busy_o, 1);
    tick();
    check_val({tag, "_idle_busy"}, busy_o, 0);
    check_val({tag, "_idle_done"}, done_o, 0);
    check_val({tag, "_blocks_hold"}, blocks_done_o, n);
    check_val({tag, "_n_core_start"}, n_core_start - cs0, n);
    check_val({tag, "_n_key_load"}, n_key_load - kl0, (n > 0) ? 1 : 0);
    check_val({tag, "_n_stclr"}, n_stclr - sc0, (n > 0) ? 1 : 0);
    check_val({tag, "_n_done"}, n_done - dn0, 1);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [127:0] d;
    int t;
    rst_i = 1'b1; clr_i = 1'b0; start_i = 1'b0; num_blocks_i = '0;
    in_valid_i = 1'b0; in_data_i = '0; key_ready_i = 1'b1; out_ready_i = 1'b0;
    spur_done = 1'b0; spur_data = '0; core_abort = 1'b0;
    repeat (3) tick();
    check_all_zero("rst");
    rst_i = 1'b0;
    tick();
    check_all_zero("post_rst");

    // Single block, exact cycle timeline with L=10 and no backpressure.
    d = rand128();
    in_data_i = d; in_valid_i = 1'b1; out_ready_i = 1'b1;
    start_i = 1'b1; num_blocks_i = 1;
    for (int c = 0; c <= 16; c++) begin
      check_val($sformatf("t1_state_c%0d", c), dut.r_state, t1_state(c));
      if (c == 1) begin
        check_val("t1_stclr", stacker_clr_o, 1);
        check_val("t1_key_load", key_load_o, 1);
      end
      if (c == 15) begin
        check_val("t1_done", done_o, 1);
        check_val("t1_blocks", blocks_done_o, 1);
        check_val("t1_out_data", out_data_o, aes_model(d));
      end
      tick();
      start_i = 1'b0;
    end
    in_valid_i = 1'b0; out_ready_i = 1'b0;

    run_job("zero", 0, 0, 1, 0, 1'b0);
    run_job("three", 3, 4, 5, 0, 1'b0);
    run_job("keydly", 1, 0, 1, 20, 1'b0);

    // Soft clear while the core is running, then a late done from the core.
    start_i = 1'b1; num_blocks_i = 1;
    tick();
    start_i = 1'b0;
    in_data_i = rand128(); in_valid_i = 1'b1;
    t = 0;
    while (!in_ready_o && t < 50) begin tick(); t++; end
    tick();
    in_valid_i = 1'b0;
    tick();
    tick();
    check_val("clr_in_run", dut.r_state, ST_RUN);
    clr_i = 1'b1; core_abort = 1'b1;
    tick();
    clr_i = 1'b0;
    check_all_zero("clr");
    tick();
    spur_done = 1'b1; spur_data = rand128();
    tick();
    spur_done = 1'b0;
    check_val("clr_late_state", dut.r_state, ST_IDLE);
    tick();
    check_all_zero("clr_late");
    core_abort = 1'b0;
    run_job("after_clr", 1, 0, 1, 0, 1'b0);

    run_job("spur", 2, 2, 3, 0, 1'b1);

    tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
